// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and framing constants shared by the UART rx and tx blocks.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} uart_state_t;
    localparam int CLK_BAUD_DEF = 870;
    localparam int DATA_BITS_N  = 8;
    localparam int FRAME_BITS   = 10;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO with async reset; pointers wrap modulo DEPTH (power of 2).
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [7:0]             i_data,
    output logic [7:0]             o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = r_count == CNTW'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + CNTW'(w_push) - CNTW'(w_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 transmitter fed by a small FIFO; frames go out back-to-back while bytes are queued.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_BAUD   = CLK_BAUD_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] in_bits,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       TX,
    output logic       busy,
    output logic       tx_done
);
    localparam int CW = $clog2(CLK_BAUD);
    uart_state_t              r_state;
    logic [CW-1:0]            r_cnt;
    logic [2:0]               r_idx;
    logic [7:0]               r_shift;
    logic                     r_tx;
    logic                     r_done;
    logic                     w_full;
    logic                     w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    logic [7:0]               w_head;
    logic                     w_bit_end;
    logic                     w_pop;
    assign w_bit_end = r_cnt == CW'(CLK_BAUD - 1);
    // Pop on idle or exactly at the stop-bit end so consecutive frames abut.
    assign w_pop     = !w_empty && (r_state == IDLE || (r_state == STOP_BIT && w_bit_end));
    assign in_ready  = !w_full;
    assign busy      = r_state != IDLE || w_count != '0;
    assign TX        = r_tx;
    assign tx_done   = r_done;
    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(CLK),
        .rst(RST),
        .i_push(in_valid && in_ready),
        .i_pop(w_pop),
        .i_data(in_bits),
        .o_data(w_head),
        .o_count(w_count),
        .o_full(w_full),
        .o_empty(w_empty)
    );
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_cnt  <= w_bit_end ? '0 : r_cnt + CW'(1);
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    r_tx  <= w_empty;
                    if (!w_empty) begin
                        r_shift <= w_head;
                        r_state <= START_BIT;
                    end
                end
                START_BIT: begin
                    if (w_bit_end) begin
                        r_tx    <= r_shift[0];
                        r_idx   <= '0;
                        r_state <= DATA_BITS;
                    end
                end
                DATA_BITS: begin
                    if (w_bit_end) begin
                        if (r_idx == 3'(DATA_BITS_N - 1)) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP_BIT;
                        end else begin
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                            r_idx   <= r_idx + 3'(1);
                        end
                    end
                end
                STOP_BIT: begin
                    if (w_bit_end) begin
                        r_done  <= 1'b1;
                        r_tx    <= w_empty;
                        r_shift <= w_empty ? r_shift : w_head;
                        r_state <= w_empty ? IDLE : START_BIT;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule
